if_id_queue: RTL
================

# if_id_queue

Parametrised instruction queue between the fetch (IF) and decode (ID) stages, replacing the single-entry IF/ID latch. It buffers up to DEPTH {pc, inst} pairs with a valid/ready handshake toward fetch and a stall/valid interface toward decode. It presents a zero bubble when empty and discards all contents on a control-unit flush. Fetch can therefore run ahead while decode is stalled, without losing instructions returned late from instruction memory.

## Interface
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- DEPTH, 4, number of entries; power of two, ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- if_valid  in  1  fetch presents an entry this cycle
- if_pc  in  ADDR_W  PC of the entry
- if_inst  in  INST_W  instruction of the entry
- if_ready  out  1  queue accepts an entry this cycle
- flush  in  1  discard all queued entries (branch/exception redirect)
- stall_id  in  1  ID stage is holding; no pop this cycle
- id_valid  out  1  id_pc/id_inst hold a real instruction
- id_pc  out  ADDR_W  PC to decode; zero when id_valid=0
- id_inst  out  INST_W  instruction to decode; zero when id_valid=0
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits each. Both pointers wrap modulo DEPTH. count is tracked separately, range 0..DEPTH.
- push = if_valid & if_ready & !flush. It writes the entry at wr_ptr, then wr_ptr increments.
- pop = id_valid & !stall_id & !flush. It increments rd_ptr.
- if_ready = (count != DEPTH). It is derived from registered count only. When full, a same-cycle pop does not make room; the push is refused.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- flush: has priority over push and pop. Next cycle rd_ptr = wr_ptr = 0 and count = 0. A push offered in the flush cycle is dropped. Outputs in the flush cycle still show the current head.
- Head output: id_valid = (count != 0). id_pc/id_inst = head entry when valid, otherwise all-zero (nop bubble).
- Reset (rst=0, asynchronous): pointers 0, count 0. Outputs are therefore id_valid=0, id_pc=0, id_inst=0, and if_ready=1. Reset mid-operation discards all entries immediately.

## Timing
- Without bypass, an entry pushed at edge N is visible on id_* in cycle N+1 at the earliest. Minimum latency is 1 cycle.
- id_* are held stable while stall_id=1 and no flush occurs.
- Throughput is 1 push and 1 pop per cycle when 0 < count < DEPTH.
- No combinational path from stall_id to if_ready.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined: when count = 0, if_valid = 1 and flush = 0, id_valid = 1 and id_pc/id_inst = if_pc/if_inst combinationally.
  - If stall_id = 0, the entry is consumed directly and not written; count stays 0.
  - If stall_id = 1, the entry is written normally and count becomes 1.
  - Latency with bypass is 0 cycles when empty.
- Without the macro: no if_* → id_* combinational path; behaviour is exactly as in Operation.

## Structure
- Shared macro file holds RSTENABLE (0 for this active-low block), ZEROWORD, INSTADDRBUS/INSTBUS defaults, and the default values of ADDR_W/INST_W.
- One sub-module, if_id_queue_mem:
  - DEPTH × (ADDR_W+INST_W) register array.
  - One synchronous write port and one combinational read port.
  - No reset on the array; validity comes from count only.
- Pointer, count and handshake logic stay in if_id_queue.

## Test plan
- Reset then idle: after rst released, id_valid=0, id_pc=0, id_inst=0, if_ready=1, count=0.
- Fill with stall: stall_id=1, push pc 0x100, 0x104, 0x108, 0x10C (DEPTH=4) → count=4, if_ready=0. A fifth push of 0x110 is refused. id_pc stays 0x100.
- Drain order: from full, stall_id=0 for 4 cycles → id_pc sequence 0x100, 0x104, 0x108, 0x10C, then id_valid=0 with zero outputs.
- Wrap-around: stream 10 entries with alternating stall_id → id_pc order matches push order across pointer wrap. count never exceeds 4.
- Flush with concurrent push: count=3 and a push of 0x200 in the flush cycle → next cycle count=0, id_valid=0. 0x200 never appears on id_pc.
- Bypass (macro defined): empty queue, push 0x300 with stall_id=0 → id_pc=0x300 in the same cycle, count stays 0. Repeat with stall_id=1 → count=1 next cycle, id_pc=0x300 held.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared reset polarity, zero word and default bus widths for the IF/ID queue
package if_id_queue_pkg;
  localparam logic RSTENABLE = 1'b0;
  localparam logic [31:0] ZEROWORD = 32'h0;
  localparam int INSTADDRBUS = 32;
  localparam int INSTBUS = 32;
  localparam int ADDR_W_DEF = INSTADDRBUS;
  localparam int INST_W_DEF = INSTBUS;
  localparam int DEPTH_DEF = 4;
endpackage

// File: rtl/if_id_queue_mem.sv
// if_id_queue_mem: DEPTH-entry register array, one synchronous write port, one combinational read port
module if_id_queue_mem #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: circular instruction queue between fetch and decode with flush and nop bubble
// Define IF_ID_QUEUE_BYPASS_EN to forward fetch straight to decode when the queue is empty.
module if_id_queue import if_id_queue_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [INST_W-1:0]        if_inst,
  output logic                     if_ready,
  input  logic                     flush,
  input  logic                     stall_id,
  output logic                     id_valid,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [INST_W-1:0]        id_inst,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int W = ADDR_W + INST_W;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rdata, head;
  logic          push, pop, byp;
`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp = (count_q == '0) && if_valid && !flush;
`else
  assign byp = 1'b0;
`endif
  assign if_ready = count_q != CW'(DEPTH);
  assign id_valid = (count_q != '0) || byp;
  assign head     = byp ? {if_pc, if_inst} : rdata;
  assign id_pc    = id_valid ? head[W-1:INST_W] : ADDR_W'(ZEROWORD);
  assign id_inst  = id_valid ? head[INST_W-1:0] : INST_W'(ZEROWORD);
  assign count    = count_q;
  // a bypassed entry consumed by decode never lands in the array
  assign push = if_valid && if_ready && !flush && !(byp && !stall_id);
  assign pop  = (count_q != '0) && !stall_id && !flush;
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  if_id_queue_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata ({if_pc, if_inst}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
endmodule
